// File: rtl/obi_arb_pkg.sv
// rtl/obi_arb_pkg.sv - shared types for the instr/data OBI memory arbiter
package obi_arb_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } obi_src_e;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/obi_id_fifo.sv
// rtl/obi_id_fifo.sv - in-order FIFO of transfer sources awaiting a memory response
module obi_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  obi_src_e src_i,
    input  logic     pop_i,
    output logic     full_o,
    output logic     empty_o,
    output obi_src_e head_o
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    // Storage is rounded up to a power of two so pointers index it at full width.
    localparam int SLOTS = 1 << PTR_W;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] FULL_CNT  = PTR_W'(DEPTH);

    obi_src_e         slots_q [SLOTS];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = slots_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SLOTS; i++) begin
                slots_q[i] <= SRC_INSTR;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                slots_q[wr_ptr_q] <= src_i;
                wr_ptr_q          <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + PTR_W'(1);
                2'b01:   count_q <= count_q - PTR_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/obi_mem_arbiter.sv
// rtl/obi_mem_arbiter.sv - shares one OBI memory port between core instr and data ports
module obi_mem_arbiter
    import obi_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ARB_MODE        = ARB_RR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic [31:0] data_addr_i,
    input  logic [3:0]  data_be_i,
    input  logic        data_we_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    lock_state_e lock_state_q;
    obi_src_e    lock_src_q;
    obi_src_e    rr_q;
    obi_src_e    owner;
    obi_src_e    fifo_head;
    logic        owner_req;
    logic        handshake;
    logic        fifo_full;
    logic        fifo_empty;
    logic        rsp_valid;

    always_comb begin
        owner = SRC_INSTR;
        if (lock_state_q == LOCK_LOCKED) begin
            owner = lock_src_q;
        end else if (ARB_MODE == ARB_FIXED) begin
            owner = data_req_i ? SRC_DATA : SRC_INSTR;
        end else if (data_req_i && instr_req_i) begin
            owner = rr_q;
        end else begin
            owner = data_req_i ? SRC_DATA : SRC_INSTR;
        end
    end

    assign owner_req = (owner == SRC_DATA) ? data_req_i : instr_req_i;
    // Full blocks the request even when a pop lands this cycle, keeping rvalid off the req path.
    assign mem_req_o = owner_req && !fifo_full && !rst_i;
    assign handshake = mem_req_o && mem_gnt_i;

    assign mem_addr_o  = (owner == SRC_DATA) ? data_addr_i  : instr_addr_i;
    assign mem_be_o    = (owner == SRC_DATA) ? data_be_i    : 4'hF;
    assign mem_we_o    = (owner == SRC_DATA) ? data_we_i    : 1'b0;
    assign mem_wdata_o = (owner == SRC_DATA) ? data_wdata_i : 32'h0;

    assign instr_gnt_o = handshake && (owner == SRC_INSTR);
    assign data_gnt_o  = handshake && (owner == SRC_DATA);

    assign rsp_valid      = mem_rvalid_i && !fifo_empty && !rst_i;
    assign instr_rvalid_o = rsp_valid && (fifo_head == SRC_INSTR);
    assign data_rvalid_o  = rsp_valid && (fifo_head == SRC_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_state_q <= LOCK_IDLE;
            lock_src_q   <= SRC_DATA;
            rr_q         <= SRC_DATA;
        end else begin
            case (lock_state_q)
                LOCK_IDLE: begin
                    if (mem_req_o && !mem_gnt_i) begin
                        lock_state_q <= LOCK_LOCKED;
                        lock_src_q   <= owner;
                    end
                end
                LOCK_LOCKED: begin
                    // A dropped request releases the port without any transfer.
                    if (handshake || !owner_req) begin
                        lock_state_q <= LOCK_IDLE;
                    end
                end
                default: lock_state_q <= LOCK_IDLE;
            endcase
            if (handshake) begin
                rr_q <= (owner == SRC_DATA) ? SRC_INSTR : SRC_DATA;
            end
        end
    end

    obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (handshake),
        .src_i   (owner),
        .pop_i   (mem_rvalid_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i) begin
            unexpected_rvalid: assert (!(mem_rvalid_i && fifo_empty))
                else $warning("obi_mem_arbiter: mem_rvalid_i with no outstanding transfer");
            locked_req_drop: assert (!(lock_state_q == LOCK_LOCKED && !owner_req))
                else $warning("obi_mem_arbiter: owner dropped req while locked");
        end
    end
`endif

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// tb/tb_obi_mem_arbiter.sv - directed bench for obi_mem_arbiter (round-robin and fixed)
module tb_obi_mem_arbiter;

    localparam logic [31:0] I_ADDR = 32'h0200_0000;
    localparam logic [31:0] D_ADDR = 32'h1000_0040;

    logic        clk = 1'b0;
    logic        rst_rr, rst_fx;
    logic        instr_req, data_req, data_we, mem_gnt, mem_rvalid;
    logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;
    logic [3:0]  data_be;

    logic        rr_instr_gnt, rr_instr_rvalid, rr_data_gnt, rr_data_rvalid, rr_mem_req, rr_mem_we;
    logic [31:0] rr_instr_rdata, rr_data_rdata, rr_mem_addr, rr_mem_wdata;
    logic [3:0]  rr_mem_be;
    logic        fx_instr_gnt, fx_instr_rvalid, fx_data_gnt, fx_data_rvalid, fx_mem_req, fx_mem_we;
    logic [31:0] fx_instr_rdata, fx_data_rdata, fx_mem_addr, fx_mem_wdata;
    logic [3:0]  fx_mem_be;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    obi_mem_arbiter #(.MAX_OUTSTANDING(2), .ARB_MODE(0)) u_rr (
        .clk_i(clk), .rst_i(rst_rr),
        .instr_req_i(instr_req), .instr_gnt_o(rr_instr_gnt), .instr_rvalid_o(rr_instr_rvalid),
        .instr_addr_i(instr_addr), .instr_rdata_o(rr_instr_rdata),
        .data_req_i(data_req), .data_gnt_o(rr_data_gnt), .data_rvalid_o(rr_data_rvalid),
        .data_addr_i(data_addr), .data_be_i(data_be), .data_we_i(data_we),
        .data_wdata_i(data_wdata), .data_rdata_o(rr_data_rdata),
        .mem_req_o(rr_mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_addr_o(rr_mem_addr), .mem_be_o(rr_mem_be), .mem_we_o(rr_mem_we),
        .mem_wdata_o(rr_mem_wdata), .mem_rdata_i(mem_rdata)
    );

    obi_mem_arbiter #(.MAX_OUTSTANDING(2), .ARB_MODE(1)) u_fx (
        .clk_i(clk), .rst_i(rst_fx),
        .instr_req_i(instr_req), .instr_gnt_o(fx_instr_gnt), .instr_rvalid_o(fx_instr_rvalid),
        .instr_addr_i(instr_addr), .instr_rdata_o(fx_instr_rdata),
        .data_req_i(data_req), .data_gnt_o(fx_data_gnt), .data_rvalid_o(fx_data_rvalid),
        .data_addr_i(data_addr), .data_be_i(data_be), .data_we_i(data_we),
        .data_wdata_i(data_wdata), .data_rdata_o(fx_data_rdata),
        .mem_req_o(fx_mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_addr_o(fx_mem_addr), .mem_be_o(fx_mem_be), .mem_we_o(fx_mem_we),
        .mem_wdata_o(fx_mem_wdata), .mem_rdata_i(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic ir, input logic dr, input logic g, input logic rv,
                         input logic [31:0] rd);
        @(negedge clk);
        instr_req  = ir;
        data_req   = dr;
        mem_gnt    = g;
        mem_rvalid = rv;
        mem_rdata  = rd;
        #1;
    endtask

    initial begin
        rst_rr = 1'b1; rst_fx = 1'b1;
        instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 32'h0; instr_addr = I_ADDR; data_addr = D_ADDR;
        data_be = 4'h3; data_we = 1'b0; data_wdata = 32'h0;

        // Reset: all handshake outputs held low regardless of inputs.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0);
        check("rst_mem_req",   32'(rr_mem_req), 0);
        check("rst_instr_gnt", 32'(rr_instr_gnt), 0);
        check("rst_data_gnt",  32'(rr_data_gnt), 0);
        check("rst_irvalid",   32'(rr_instr_rvalid), 0);
        check("rst_drvalid",   32'(rr_data_rvalid), 0);
        instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        rst_rr = 1'b0;

        // 1: single instruction fetch.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        check("t1_instr_gnt", 32'(rr_instr_gnt), 1);
        check("t1_data_gnt",  32'(rr_data_gnt), 0);
        check("t1_addr",      rr_mem_addr, I_ADDR);
        check("t1_be",        32'(rr_mem_be), 32'hF);
        check("t1_we",        32'(rr_mem_we), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0013);
        check("t1_irvalid", 32'(rr_instr_rvalid), 1);
        check("t1_irdata",  rr_instr_rdata, 32'h13);
        check("t1_drvalid", 32'(rr_data_rvalid), 0);

        // 2: round-robin with both requesting, starting from data.
        data_we = 1'b1; data_wdata = 32'hCAFE_0001;
        for (int k = 0; k < 5; k++) begin
            drive(k < 4, k < 4, k < 4, k >= 1, 32'hA0 + k);
            check($sformatf("t2_dgnt%0d", k),   32'(rr_data_gnt),    32'(k < 4 && k % 2 == 0));
            check($sformatf("t2_ignt%0d", k),   32'(rr_instr_gnt),   32'(k < 4 && k % 2 == 1));
            check($sformatf("t2_drv%0d", k),    32'(rr_data_rvalid), 32'(k % 2 == 1));
            check($sformatf("t2_irv%0d", k),    32'(rr_instr_rvalid), 32'(k >= 2 && k % 2 == 0));
            if (k < 4) begin
                check($sformatf("t2_addr%0d", k), rr_mem_addr, (k % 2 == 0) ? D_ADDR : I_ADDR);
                check($sformatf("t2_we%0d", k),   32'(rr_mem_we), 32'(k % 2 == 0));
            end
        end
        data_we = 1'b0; data_wdata = 32'h0;

        // Data-only read leaves the rr pointer on instr.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("br_dgnt", 32'(rr_data_gnt), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h55);
        check("br_drv",   32'(rr_data_rvalid), 1);
        check("br_drdat", rr_data_rdata, 32'h55);

        // 3: data locked while memory stalls; instr cannot steal the port.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("t3_req0",  32'(rr_mem_req), 1);
        check("t3_dgnt0", 32'(rr_data_gnt), 0);
        for (int k = 1; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            check($sformatf("t3_addr%0d", k), rr_mem_addr, D_ADDR);
            check($sformatf("t3_ignt%0d", k), 32'(rr_instr_gnt), 0);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t3_dgnt3", 32'(rr_data_gnt), 1);
        check("t3_ignt3", 32'(rr_instr_gnt), 0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h77);
        check("t3_ignt4", 32'(rr_instr_gnt), 1);
        check("t3_drv4",  32'(rr_data_rvalid), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h78);
        check("t3_irv5",  32'(rr_instr_rvalid), 1);
        check("t3_irdat", rr_instr_rdata, 32'h78);

        // 4: two outstanding fills the FIFO; request held off until a response drains one.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        check("t4_gnt0", 32'(rr_instr_gnt), 1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        check("t4_gnt1", 32'(rr_instr_gnt), 1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        check("t4_req2", 32'(rr_mem_req), 0);
        check("t4_gnt2", 32'(rr_instr_gnt), 0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h101);
        check("t4_req3", 32'(rr_mem_req), 0);
        check("t4_irv3", 32'(rr_instr_rvalid), 1);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h102);
        check("t4_req4", 32'(rr_mem_req), 1);
        check("t4_gnt4", 32'(rr_instr_gnt), 1);
        check("t4_irv4", 32'(rr_instr_rvalid), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h103);
        check("t4_irv5", 32'(rr_instr_rvalid), 1);

        // 5: reset with one transfer outstanding, then a stale response.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t5_dgnt0", 32'(rr_data_gnt), 1);
        @(negedge clk);
        rst_rr = 1'b1; instr_req = 1'b1; data_req = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b0;
        #1;
        check("t5_rst_req",  32'(rr_mem_req), 0);
        check("t5_rst_dgnt", 32'(rr_data_gnt), 0);
        check("t5_rst_ignt", 32'(rr_instr_gnt), 0);
        instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0;
        rst_rr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hBAD);
        check("t5_stale_drv", 32'(rr_data_rvalid), 0);
        check("t5_stale_irv", 32'(rr_instr_rvalid), 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t5_rr_dgnt", 32'(rr_data_gnt), 1);
        check("t5_rr_ignt", 32'(rr_instr_gnt), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h5A);
        check("t5_drv", 32'(rr_data_rvalid), 1);
        check("t5_irv", 32'(rr_instr_rvalid), 0);
        drive(1'b0, 1'b0, 1'b0, 0, 32'h0);

        // 6: fixed priority starves instr while data keeps requesting.
        rst_rr = 1'b1;
        rst_fx = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b1, k >= 1, 32'hF0 + k);
            check($sformatf("t6_dgnt%0d", k), 32'(fx_data_gnt), 1);
            check($sformatf("t6_ignt%0d", k), 32'(fx_instr_gnt), 0);
            check($sformatf("t6_drv%0d", k),  32'(fx_data_rvalid), 32'(k >= 1));
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hF4);
        check("t6_ignt4", 32'(fx_instr_gnt), 1);
        check("t6_drv4",  32'(fx_data_rvalid), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hF5);
        check("t6_irv5",  32'(fx_instr_rvalid), 1);
        check("t6_drv5",  32'(fx_data_rvalid), 0);
        check("t6_irdat", fx_instr_rdata, 32'hF5);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
